// File: rtl/julia_iter_ctrl_pkg.sv
// Shared constants and types for the Julia/Mandelbrot point iterator.
// Values are Q10.10 signed fixed point.
package julia_pkg;

    localparam int WIDTH      = 20;
    localparam int FRACTIONAL = 10;
    localparam int ITER_W     = 8;

    localparam logic signed [WIDTH-1:0] ONE_FX    = WIDTH'(1 << FRACTIONAL);
    localparam logic signed [WIDTH:0]   ESCAPE_FX = (WIDTH+1)'(4 << FRACTIONAL);

    typedef logic signed [WIDTH-1:0] fx_t;

    typedef enum logic [2:0] {
        IDLE,
        SQX,
        SQY,
        XY,
        UPD,
        DONE
    } state_e;

endpackage

// File: rtl/julia_iter_ctrl_if.sv
// Dispatcher/result-writer bundle for one iteration controller.
// master = dispatcher side, slave = controller side.
interface julia_iter_ctrl_if;
    import julia_pkg::*;

    logic              start;
    fx_t               c_re;
    fx_t               c_im;
    fx_t               z0_re;
    fx_t               z0_im;
    logic [ITER_W-1:0] max_iter;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_count;
    logic              escaped;
    fx_t               z_re;
    fx_t               z_im;

    modport master (
        output start, c_re, c_im, z0_re, z0_im, max_iter,
        input  busy, done, iter_count, escaped, z_re, z_im
    );

    modport slave (
        input  start, c_re, c_im, z0_re, z0_im, max_iter,
        output busy, done, iter_count, escaped, z_re, z_im
    );

endinterface

// File: rtl/fixed_multiplication.sv
// Combinational Q10.10 signed multiply; result floors toward -inf
// and keeps the low WIDTH bits.
module fixed_multiplication
    import julia_pkg::*;
(
    input  fx_t a_i,
    input  fx_t b_i,
    output fx_t result_o
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod     = a_i * b_i;
    assign result_o = WIDTH'(prod >>> FRACTIONAL);

endmodule

// File: rtl/julia_iter_ctrl.sv
// Iterates z <- z^2 + c on one shared multiplier (x*x, y*y, x*y),
// counting iterations until escape (|z|^2 > 4) or the limit.
module julia_iter_ctrl
    import julia_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    julia_iter_ctrl_if.slave io
);

    state_e            state_q;
    fx_t               x_q, y_q, cre_q, cim_q;
    fx_t               xx_q, yy_q, xy_q;
    logic [ITER_W-1:0] max_q, cnt_q;
    logic              esc_q;

    logic              busy_q, done_q, escd_q;
    logic [ITER_W-1:0] iter_q;
    fx_t               zre_q, zim_q;

    fx_t               mul_a, mul_b, mul_p;
    logic signed [WIDTH:0] mag;
    fx_t               x_nxt, y_nxt;
    logic [ITER_W-1:0] cnt_nxt;

    fixed_multiplication u_mult (
        .a_i      (mul_a),
        .b_i      (mul_b),
        .result_o (mul_p)
    );

    always_comb begin
        mul_a = x_q;
        mul_b = x_q;
        unique case (state_q)
            SQY: begin
                mul_a = y_q;
                mul_b = y_q;
            end
            XY:      mul_b = y_q;
            default: ;
        endcase
    end

    // Magnitude gets one guard bit so two large squares cannot wrap.
    assign mag     = {xx_q[WIDTH-1], xx_q} + {yy_q[WIDTH-1], yy_q};
    assign x_nxt   = xx_q - yy_q + cre_q;
    assign y_nxt   = (xy_q <<< 1) + cim_q;
    assign cnt_nxt = cnt_q + ITER_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cre_q   <= '0;
            cim_q   <= '0;
            xx_q    <= '0;
            yy_q    <= '0;
            xy_q    <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            esc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            escd_q  <= 1'b0;
            iter_q  <= '0;
            zre_q   <= '0;
            zim_q   <= '0;
        end else begin
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == DONE);
            unique case (state_q)
                IDLE: begin
                    if (io.start) begin
                        x_q     <= io.z0_re;
                        y_q     <= io.z0_im;
                        cre_q   <= io.c_re;
                        cim_q   <= io.c_im;
                        max_q   <= io.max_iter;
                        cnt_q   <= '0;
                        esc_q   <= 1'b0;
                        state_q <= (io.max_iter == '0) ? DONE : SQX;
                    end
                end
                SQX: begin
                    xx_q    <= mul_p;
                    state_q <= SQY;
                end
                SQY: begin
                    yy_q    <= mul_p;
                    state_q <= XY;
                end
                XY: begin
                    xy_q    <= mul_p;
                    state_q <= UPD;
                end
                UPD: begin
                    if (mag > ESCAPE_FX) begin
                        esc_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        x_q     <= x_nxt;
                        y_q     <= y_nxt;
                        cnt_q   <= cnt_nxt;
                        state_q <= (cnt_nxt == max_q) ? DONE : SQX;
                    end
                end
                DONE: begin
                    iter_q  <= cnt_q;
                    escd_q  <= esc_q;
                    zre_q   <= x_q;
                    zim_q   <= y_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.busy       = busy_q;
    assign io.done       = done_q;
    assign io.iter_count = iter_q;
    assign io.escaped    = escd_q;
    assign io.z_re       = zre_q;
    assign io.z_im       = zim_q;

endmodule
